// File: rtl/bka_multiword_seq_pkg.sv
// Shared definitions for the multi-word sequenced adder: word width,
// FSM encoding and index-width helper.
package bka_multiword_seq_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A single-word configuration still needs a one-bit index register.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/bka_32bit.sv
// 32-bit Brent-Kung prefix adder: up-sweep builds power-of-two group
// carries, down-sweep fills in the remaining positions.
module bka_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    always_comb begin : prefix
        logic [31:0] p;
        logic [31:0] g;
        logic [31:0] pp;
        logic [31:0] gg;
        p     = a ^ b;
        g     = a & b;
        pp    = p;
        gg    = g;
        // Fold carry-in into bit 0 so gg[i] becomes the carry out of bit i.
        gg[0] = g[0] | (p[0] & cin);
        for (int d = 0; d < 5; d++) begin
            for (int i = (2 << d) - 1; i < 32; i += (2 << d)) begin
                gg[i] = gg[i] | (pp[i] & gg[i - (1 << d)]);
                pp[i] = pp[i] & pp[i - (1 << d)];
            end
        end
        for (int d = 3; d >= 0; d--) begin
            for (int i = (3 << d) - 1; i < 32; i += (2 << d)) begin
                gg[i] = gg[i] | (pp[i] & gg[i - (1 << d)]);
                pp[i] = pp[i] & pp[i - (1 << d)];
            end
        end
        sum  = p ^ {gg[30:0], cin};
        cout = gg[31];
    end

endmodule

// File: rtl/bka_multiword_seq.sv
// WORDS*32-bit add/sub built from one 32-bit adder, one word per cycle LSW
// first, with the carry chained through a register between words.
module bka_multiword_seq
    import bka_multiword_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WORDS*WORD_W-1:0]   in_a,
    input  logic [WORDS*WORD_W-1:0]   in_b,
    input  logic                      in_cin,
    input  logic                      in_sub,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WORDS*WORD_W-1:0]   out_sum,
    output logic                      out_cout
);

    localparam int IDX_W = idx_width(WORDS);

    state_e                        state, state_nxt;
    logic [IDX_W-1:0]              idx;
    logic                          carry;
    logic [WORDS-1:0][WORD_W-1:0]  a_q, b_q, sum_q;
    logic                          cout_q;
    logic [WORD_W-1:0]             add_sum;
    logic                          add_cout;
    logic                          last;
    logic                          accept;
    logic                          pop;

    assign last   = (idx == IDX_W'(WORDS - 1));
    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    bka_32bit u_add (
        .a    (a_q[idx]),
        .b    (b_q[idx]),
        .cin  (carry),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) state_nxt = RUN;
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (pop) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // B is stored pre-inverted for subtraction so RUN is a plain add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            a_q   <= in_a;
            b_q   <= in_b ^ {(WORDS*WORD_W){in_sub}};
            carry <= in_sub | in_cin;
            idx   <= '0;
        end else if (state == RUN) begin
            sum_q[idx] <= add_sum;
            carry      <= add_cout;
            idx        <= last ? '0 : idx + IDX_W'(1);
            if (last) cout_q <= add_cout;
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;

endmodule
